// File: rtl/axi_bfm_pkg.sv
// axi_bfm_pkg: response codes and FSM encodings shared by the AXI slave memory
package axi_bfm_pkg;
   typedef logic [1:0] resp_t;
   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_SLVERR = 2'b10;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;
   function automatic resp_t resp_of(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction
endpackage

// File: rtl/axi_slave_mem_if.sv
// axi_slave_mem_if: AXI write/read channel bundle between a master and the slave memory
interface axi_slave_mem_if;
   import axi_bfm_pkg::*;
   logic [3:0]  awid;
   logic [31:0] awadr;
   logic [3:0]  awlen;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wrdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   resp_t       bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   resp_t       rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   modport slave (
      input  awid, awadr, awlen, awvalid, wid, wrdata, wstrb, wlast, wvalid, bready,
             arid, araddr, arlen, arvalid, rready,
      output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
   modport master (
      output awid, awadr, awlen, awvalid, wid, wrdata, wstrb, wlast, wvalid, bready,
             arid, araddr, arlen, arvalid, rready,
      input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_slave_mem_array.sv
// axi_slave_mem_array: 32-bit word store with a byte-enable write port and a registered read port
module axi_slave_mem_array #(
   parameter int AW        = 8,
   parameter int INIT_ZERO = 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [3:0]    wstrb,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] mem [2**AW] = '{default: (INIT_ZERO != 0) ? 32'h0 : 32'hx};
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
      for (int i = 0; i < 4; i++)
         if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
   end
endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI burst slave (INCR, 4-byte beats) in front of a byte-enabled word memory
module axi_slave_mem
   import axi_bfm_pkg::*;
#(
   parameter int MEM_AW    = 8,
   parameter int INIT_ZERO = 1
) (
   input logic            aclk,
   input logic            areset,
   axi_slave_mem_if.slave s
);
   w_state_e          w_state, w_next;
   r_state_e          r_state, r_next;
   logic [3:0]        w_id, w_len, w_cnt, r_id, r_len, r_cnt;
   logic [MEM_AW-1:0] w_ptr, r_ptr, rd_addr;
   logic              w_oor, w_err, r_oor;
   resp_t             w_resp;
   logic              aw_hs, w_hs, w_end, w_bad, ar_hs, r_hs, mem_we, rd_en;
   logic [31:0]       mem_q;

   always_ff @(posedge aclk) begin
      w_state <= areset ? W_IDLE : w_next;
      r_state <= areset ? R_IDLE : r_next;
   end

   always_comb begin
      s.awready = w_state == W_IDLE && !areset;
      s.wready  = w_state == W_DATA;
      s.bvalid  = w_state == W_RESP;
      s.bid     = w_id;
      s.bresp   = w_resp;
      aw_hs     = s.awvalid && s.awready;
      w_hs      = s.wvalid && s.wready;
      w_end     = s.wlast || w_cnt == w_len;
      w_bad     = s.wlast != (w_cnt == w_len) || s.wid != w_id;
      w_next    = w_state == W_IDLE ? (aw_hs ? W_DATA : W_IDLE)
                : w_state == W_DATA ? (w_hs && w_end ? W_RESP : W_DATA)
                : (s.bready ? W_IDLE : W_RESP);
      mem_we    = w_hs && !w_oor && !areset;
      s.arready = r_state == R_IDLE && !areset;
      s.rvalid  = r_state == R_DATA;
      s.rlast   = s.rvalid && r_cnt == r_len;
      s.rid     = r_id;
      s.rresp   = resp_of(r_oor);
      s.rdata   = (s.rvalid && !r_oor) ? mem_q : '0;
      ar_hs     = s.arvalid && s.arready;
      r_hs      = s.rvalid && s.rready;
      r_next    = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE)
                : (r_hs && s.rlast ? R_IDLE : R_DATA);
      // prefetch the next beat on each handshake so it is presented one cycle later
      rd_en     = ar_hs || (r_hs && !s.rlast);
      rd_addr   = ar_hs ? s.araddr[MEM_AW+1:2] : r_ptr;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         w_id   <= '0;
         w_resp <= RESP_OKAY;
         r_id   <= '0;
         r_oor  <= 1'b0;
      end else begin
         if (aw_hs) begin
            w_id  <= s.awid;
            w_len <= s.awlen;
            w_cnt <= '0;
            w_ptr <= s.awadr[MEM_AW+1:2];
            w_oor <= (s.awadr >> (MEM_AW + 2)) != 0;
            w_err <= 1'b0;
         end
         if (w_hs) begin
            w_cnt <= w_cnt + 4'd1;
            w_ptr <= w_ptr + MEM_AW'(1);
            w_err <= w_err || w_bad;
            if (w_end) w_resp <= resp_of(w_err || w_bad || w_oor);
         end
         if (ar_hs) begin
            r_id  <= s.arid;
            r_len <= s.arlen;
            r_cnt <= '0;
            r_ptr <= s.araddr[MEM_AW+1:2] + MEM_AW'(1);
            r_oor <= (s.araddr >> (MEM_AW + 2)) != 0;
         end
         if (r_hs) begin
            r_cnt <= r_cnt + 4'd1;
            r_ptr <= r_ptr + MEM_AW'(1);
         end
      end
   end

   axi_slave_mem_array #(.AW(MEM_AW), .INIT_ZERO(INIT_ZERO)) u_array (
      .clk   (aclk),
      .we    (mem_we),
      .waddr (w_ptr),
      .wstrb (s.wstrb),
      .wdata (s.wrdata),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (mem_q)
   );
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: randomized scoreboard bench for axi_slave_mem against a word-array model
module tb_axi_slave_mem;
   import axi_bfm_pkg::*;
   typedef struct packed {logic [3:0] id; resp_t resp;} b_t;
   typedef struct packed {logic [3:0] id; logic [31:0] data; resp_t resp; logic last;} r_t;
   logic aclk = 1'b0;
   logic areset = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   int rr_mode = 0;
   b_t bq[$];
   r_t rq[$];
   b_t b_exp;
   r_t r_exp;
   logic [31:0] ref_mem [256];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic        b_stall = 1'b0, r_stall = 1'b0;
   logic [5:0]  b_snap;
   logic [38:0] r_snap;
   logic [31:0] ra;
   logic [3:0]  rl;
   int          rla, rbad;

   always #5 aclk = ~aclk;

   axi_slave_mem_if bus();
   axi_slave_mem #(.MEM_AW(8), .INIT_ZERO(1)) dut (.aclk(aclk), .areset(areset), .s(bus));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic check_quiet(input string name);
      check({name, "_ctl"}, {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast}, 0);
      check({name, "_dat"}, {bus.bid, bus.bresp, bus.rid, bus.rresp, bus.rdata}, 0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 16; i++) begin
         wd[i] = $urandom();
         ws[i] = 4'($urandom_range(0, 15));
      end
   endtask

   // last_at: beat carrying wlast (beyond len means never); bad_at: beat with a wrong wid (-1 none)
   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int last_at, input int bad_at);
      int n, t, w;
      logic oor, err;
      b_t e;
      n   = (last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
      oor = (addr >> 10) != 0;
      err = oor || last_at != int'(len) || (bad_at >= 0 && bad_at < n);
      for (int b = 0; b < n; b++) begin
         w = int'(((addr >> 2) + 32'(b)) % 256);
         for (int k = 0; k < 4; k++)
            if (!oor && ws[b][k]) ref_mem[w][8*k +: 8] = wd[b][8*k +: 8];
      end
      e.id   = id;
      e.resp = err ? RESP_SLVERR : RESP_OKAY;
      bq.push_back(e);
      step();
      bus.awid = id; bus.awadr = addr; bus.awlen = len; bus.awvalid = 1'b1;
      t = 0;
      @(negedge aclk);
      while (!bus.awready && t < 50) begin @(negedge aclk); t++; end
      check("aw_accept", bus.awready, 1'b1);
      step();
      bus.awvalid = 1'b0;
      for (int b = 0; b < n; b++) begin
         if ($urandom_range(0, 3) == 0) step();
         bus.wvalid = 1'b1; bus.wid = (b == bad_at) ? ~id : id;
         bus.wrdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = (b == last_at);
         t = 0;
         @(negedge aclk);
         while (!bus.wready && t < 50) begin @(negedge aclk); t++; end
         check("w_accept", bus.wready, 1'b1);
         step();
         bus.wvalid = 1'b0; bus.wlast = 1'b0;
      end
      t = 0;
      while (bq.size() != 0 && t < 100) begin @(negedge aclk); t++; end
      check("b_drain", bq.size(), 0);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
      int t;
      logic oor;
      r_t e;
      oor = (addr >> 10) != 0;
      for (int b = 0; b <= int'(len); b++) begin
         e.id   = id;
         e.data = oor ? 32'h0 : ref_mem[int'(((addr >> 2) + 32'(b)) % 256)];
         e.resp = oor ? RESP_SLVERR : RESP_OKAY;
         e.last = (b == int'(len));
         rq.push_back(e);
      end
      step();
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
      t = 0;
      @(negedge aclk);
      while (!bus.arready && t < 50) begin @(negedge aclk); t++; end
      check("ar_accept", bus.arready, 1'b1);
      step();
      bus.arvalid = 1'b0;
      t = 0;
      while (rq.size() != 0 && t < 200) begin @(negedge aclk); t++; end
      check("r_drain", rq.size(), 0);
   endtask

   initial begin
      bus.bready = 1'b0;
      bus.rready = 1'b0;
      forever begin
         step();
         bus.bready = $urandom_range(0, 3) != 0;
         bus.rready = (rr_mode != 0) ? !bus.rready : ($urandom_range(0, 3) != 0);
      end
   end

   always @(negedge aclk) begin
      if (!areset) begin
         if (b_stall && bus.bvalid) check("b_stable", {bus.bid, bus.bresp}, b_snap);
         if (r_stall && bus.rvalid) check("r_stable", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, r_snap);
         if (bus.bvalid && bus.bready) begin
            if (bq.size() == 0) check("b_spurious", bus.bvalid, 1'b0);
            else begin
               b_exp = bq.pop_front();
               check("bid", bus.bid, b_exp.id);
               check("bresp", bus.bresp, b_exp.resp);
            end
         end
         if (bus.rvalid && bus.rready) begin
            if (rq.size() == 0) check("r_spurious", bus.rvalid, 1'b0);
            else begin
               r_exp = rq.pop_front();
               check("rid", bus.rid, r_exp.id);
               check("rdata", bus.rdata, r_exp.data);
               check("rresp", bus.rresp, r_exp.resp);
               check("rlast", bus.rlast, r_exp.last);
            end
         end
      end
      b_stall = !areset && bus.bvalid && !bus.bready;
      b_snap  = {bus.bid, bus.bresp};
      r_stall = !areset && bus.rvalid && !bus.rready;
      r_snap  = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
      bus.awid = '0; bus.awadr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
      bus.wid = '0; bus.wrdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check_quiet("reset");
      step();
      areset = 1'b0;
      @(negedge aclk);
      check("ready_after_reset", {bus.awready, bus.arready}, 2'b11);
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
      do_write(4'd3, 32'h10, 4'd3, 3, -1);
      do_read(4'd7, 32'h10, 4'd3);
      wd[0] = 32'hFFFF_FFFF; ws[0] = 4'h5;
      do_write(4'd1, 32'h80, 4'd0, 0, -1);
      do_read(4'd2, 32'h80, 4'd0);
      fill_random();
      do_write(4'd2, 32'h20, 4'd3, 1, -1);
      do_read(4'd2, 32'h20, 4'd3);
      fill_random();
      do_write(4'd6, 32'h30, 4'd3, 15, -1);
      fill_random();
      do_write(4'd6, 32'h40, 4'd2, 2, 1);
      do_read(4'd4, 32'h30, 4'd6);
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom(); ws[i] = 4'hF; end
      do_write(4'd0, 32'h0, 4'd3, 3, -1);
      fill_random();
      do_write(4'd4, 32'h400, 4'd3, 3, -1);
      do_read(4'd1, 32'h0, 4'd3);
      do_read(4'd1, 32'h400, 4'd1);
      fill_random();
      do_write(4'd5, 32'h3F8, 4'd3, 3, -1);
      do_read(4'd5, 32'h3F8, 4'd3);
      rr_mode = 1;
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom(); ws[i] = 4'hF; end
      do_write(4'd9, 32'h100, 4'd15, 15, -1);
      do_read(4'd9, 32'h100, 4'd15);
      rr_mode = 0;
      fill_random();
      fork
         do_write(4'hA, 32'h300, 4'd7, 7, -1);
         do_read(4'hB, 32'h10, 4'd3);
      join
      for (int it = 0; it < 24; it++) begin
         ra   = ($urandom_range(0, 5) == 0) ? ($urandom() | 32'h400) : 32'($urandom_range(0, 1023));
         rl   = 4'($urandom_range(0, 15));
         rla  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'(rl);
         rbad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(rl))) : -1;
         fill_random();
         do_write(4'($urandom_range(0, 15)), ra, rl, rla, rbad);
         do_read(4'($urandom_range(0, 15)), ra, rl);
      end
      step();
      bus.awid = 4'h2; bus.awadr = 32'h200; bus.awlen = 4'd7; bus.awvalid = 1'b1;
      @(negedge aclk);
      check("aw_ready_mid", bus.awready, 1'b1);
      step();
      bus.awvalid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         bus.wvalid = 1'b1; bus.wid = 4'h2; bus.wrdata = $urandom(); bus.wstrb = 4'hF; bus.wlast = 1'b0;
         @(negedge aclk);
         check("w_ready_mid", bus.wready, 1'b1);
         ref_mem[128 + b] = bus.wrdata;
         step();
      end
      bus.wvalid = 1'b0;
      areset = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check_quiet("mid_reset");
      step();
      areset = 1'b0;
      @(negedge aclk);
      check("ready_after_mid_reset", {bus.awready, bus.arready}, 2'b11);
      for (int i = 0; i < 4; i++) begin wd[i] = $urandom(); ws[i] = 4'hF; end
      do_write(4'hC, 32'h240, 4'd3, 3, -1);
      do_read(4'hD, 32'h200, 4'd3);
      do_read(4'hE, 32'h240, 4'd3);
      repeat (4) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
